debug_uart_arbiter: RTL
=======================

Name: debug_uart_arbiter

Overview:
- Shares the single debug UART transmitter (115200 baud, 27 MHz `clk`) between several on-chip message sources.
- Arbitration is round-robin at message granularity. A grant is held from the first byte to the byte flagged `last`, so messages never interleave on `uart_tx`.
- Sits between the message producers (counter reporter, CPU trace, etc.) and the byte-wide serializer.
- A stall watchdog releases a requester that hangs mid-message.

Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `TIMEOUT_CYC`, 270000, cycles with no accepted byte while granted before forced release (10 ms at 27 MHz).
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester index.

Ports:
- `clk` input 1: system clock, 27 MHz.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: per-requester byte valid.
- `req_data` input `NUM_REQ*8`: per-requester byte; requester i uses bits `[8i+7:8i]`.
- `req_last` input `NUM_REQ`: marks the final byte of a message.
- `req_ready` output `NUM_REQ`: byte accepted from requester i when `req_valid[i]` and `req_ready[i]` are both high.
- `tx_data` output 8: byte to the serializer.
- `tx_valid` output 1: serializer byte valid.
- `tx_ready` input 1: serializer can accept a byte.
- `busy` output 1: a grant is active or `tx_valid` is high.
- `grant_id` output `ID_W`: index of the current or most recent grant.
- `abort_pulse` output 1: one-cycle pulse on watchdog release.

Behaviour:
- **Reset values:** `tx_valid`=0, `tx_data`=0, `req_ready`=0, `busy`=0, `grant_id`=0, `abort_pulse`=0. The round-robin pointer resets to `NUM_REQ-1`, so requester 0 wins first. State resets to IDLE and the watchdog counter to 0.
- **Output register:**
  - `tx_data`/`tx_valid` are registered, one-entry holding slot.
  - Slot free = `!tx_valid || tx_ready`.
  - `tx_data` is held stable while `tx_valid && !tx_ready`.
- **States:** IDLE, (PFX_ID, PFX_COLON when the feature is enabled), PASS.
- **IDLE:**
  - If any `req_valid` is high, grant the first valid index searching upward from pointer+1, with wrap.
  - Register `grant_id` and update the pointer to it.
  - Go to PASS (or PFX_ID) next cycle. Arbitration costs 1 cycle.
  - Only `req_valid` is sampled in IDLE; `req_ready` stays 0.
- **PASS:**
  - `req_ready[grant_id]` = slot free (combinational from `tx_ready`). All other `req_ready` bits are 0.
  - On an accepted byte: the slot loads the byte next cycle and the watchdog clears.
  - If the accepted byte has `req_last`, go to IDLE. The slot may still be draining; re-arbitration may overlap the drain, but no new byte is accepted until the slot is free.
- **Watchdog:**
  - In PASS, the counter increments each cycle with no accepted byte.
  - On reaching `TIMEOUT_CYC-1`: go to IDLE and pulse `abort_pulse` for exactly 1 cycle.
  - Any byte already in the slot is still sent. No terminator is inserted.
  - The pointer keeps the aborted index, so the next grant goes elsewhere first.
  - A stall waiting on `tx_ready` with the slot full does not count; the counter only runs when `req_ready` is high.
- **Simultaneous events:** a last-byte accept and the timeout in the same cycle count as an accept; no abort is raised.
- **`busy`** = (state != IDLE) || `tx_valid`.
- **Reset mid-message:** all state clears immediately (asynchronous). A partially sent UART frame is the serializer's responsibility. After release, the arbiter restarts at requester 0.
- **`req_valid` dropping** while granted is legal; the grant is held until last or timeout.

Optional Feature:
- Macro: `DEBUG_UART_ARB_PREFIX_EN`.
- **When defined:** after a grant, the arbiter emits two bytes through the slot before PASS:
  - ASCII `'0'`+`grant_id` (PFX_ID),
  - then `':'` (0x3A) (PFX_COLON).
  - Each prefix byte waits for slot free. `req_ready` is 0 during the prefix. The watchdog is idle during the prefix.
- **When undefined:** PFX states do not exist, IDLE goes directly to PASS, and the output stream is exactly the requester bytes.

Decomposition:
- Package `debug_uart_pkg`:
  - state enum (IDLE, PFX_ID, PFX_COLON, PASS),
  - `UART_BYTE_W`=8,
  - `ASCII_ZERO`=8'h30, `ASCII_COLON`=8'h3A,
  - default `TIMEOUT_CYC`.
- One sub-module, `rr_pick`: a combinational round-robin priority finder taking (`req_valid`, pointer) and returning (hit, index). It is reused by other arbiters in the codebase.

Test Plan:
- **Single requester:** req1 sends "Hi\r" (0x48,0x69,0x0D, last on 0x0D), `tx_ready` pulsed every 234 cycles → `tx_data` sequence 48,69,0D. `grant_id`=1. `busy` falls after the 0x0D handshake.
- **Contention:** req0 sends "AB" and req2 sends "XY" at the same time → output A,B,X,Y with no interleave. Both requesters then re-request → 2 is not granted before 0 only if the pointer says so; expected order after reset: 0,2,0,2.
- **Backpressure:** hold `tx_ready`=0 for 1000 cycles with a byte in the slot → `tx_data` is stable, `req_ready`=0, and no abort occurs.
- **Watchdog:** req3 sends 1 non-last byte then stalls, with `TIMEOUT_CYC`=100 → `abort_pulse` is high for exactly 1 cycle, 100 cycles after the accept. Next, req0 is granted.
- **Prefix:** with `DEBUG_UART_ARB_PREFIX_EN`, req2 sends "Z" → bytes 0x32,0x3A,0x5A.
- **Reset mid-message:** assert `rst` mid-stream → all outputs reach reset values asynchronously. After release, req0 wins over req1.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART message arbiter.
package debug_uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PFX_ID    = 2'd1,
      PFX_COLON = 2'd2,
      PASS      = 2'd3
   } state_t;

   localparam int         UART_BYTE_W         = 8;
   localparam logic [7:0] ASCII_ZERO          = 8'h30;
   localparam logic [7:0] ASCII_COLON         = 8'h3A;
   localparam int         TIMEOUT_CYC_DEFAULT = 270000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of valid searching upward from ptr+1, with wrap.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic          hit,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(ptr) + k) % N);
         if (valid[cand]) begin
            hit = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/debug_uart_arbiter.sv
// Message-granular round-robin arbiter in front of the debug UART serializer, with stall watchdog.
// Define DEBUG_UART_ARB_PREFIX_EN to emit "<id>:" ahead of every granted message.
module debug_uart_arbiter
   import debug_uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*UART_BYTE_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]               req_last,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [UART_BYTE_W-1:0]           tx_data,
   output logic                             tx_valid,
   input  logic                             tx_ready,
   output logic                             busy,
   output logic [ID_W-1:0]                  grant_id,
   output logic                             abort_pulse
);

   localparam int WD_W = $clog2(TIMEOUT_CYC);

   state_t                 state, state_nxt;
   logic [ID_W-1:0]        ptr, ptr_nxt, grant_id_nxt;
   logic [WD_W-1:0]        wd, wd_nxt;
   logic                   abort_nxt;
   logic                   load;
   logic [UART_BYTE_W-1:0] load_data;
   logic                   slot_free;
   logic                   accept;
   logic                   pick_hit;
   logic [ID_W-1:0]        pick_idx;
   logic [UART_BYTE_W-1:0] gnt_byte;
   logic                   gnt_valid, gnt_last;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .hit   (pick_hit),
      .idx   (pick_idx)
   );

   assign slot_free = !tx_valid || tx_ready;
   assign gnt_valid = req_valid[grant_id];
   assign gnt_last  = req_last[grant_id];
   assign gnt_byte  = req_data[int'(grant_id)*UART_BYTE_W +: UART_BYTE_W];
   assign busy      = (state != IDLE) || tx_valid;

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      grant_id_nxt = grant_id;
      wd_nxt       = wd;
      abort_nxt    = 1'b0;
      load         = 1'b0;
      load_data    = gnt_byte;
      req_ready    = '0;
      accept       = 1'b0;
      case (state)
         IDLE: begin
            wd_nxt = '0;
            if (pick_hit) begin
               grant_id_nxt = pick_idx;
               ptr_nxt      = pick_idx;
`ifdef DEBUG_UART_ARB_PREFIX_EN
               state_nxt    = PFX_ID;
`else
               state_nxt    = PASS;
`endif
            end
         end
`ifdef DEBUG_UART_ARB_PREFIX_EN
         PFX_ID: begin
            if (slot_free) begin
               load      = 1'b1;
               load_data = ASCII_ZERO + UART_BYTE_W'(grant_id);
               state_nxt = PFX_COLON;
            end
         end
         PFX_COLON: begin
            if (slot_free) begin
               load      = 1'b1;
               load_data = ASCII_COLON;
               state_nxt = PASS;
            end
         end
`endif
         PASS: begin
            req_ready[grant_id] = slot_free;
            accept              = slot_free && gnt_valid;
            if (accept) begin
               load   = 1'b1;
               wd_nxt = '0;
               if (gnt_last) state_nxt = IDLE;
            end else if (slot_free) begin
               // Only an offered-but-unused slot counts as a stall; a full slot waiting on the serializer does not.
               if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                  state_nxt = IDLE;
                  abort_nxt = 1'b1;
                  wd_nxt    = '0;
               end else begin
                  wd_nxt = wd + WD_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= ID_W'(NUM_REQ - 1);
         grant_id    <= '0;
         wd          <= '0;
         abort_pulse <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         grant_id    <= grant_id_nxt;
         wd          <= wd_nxt;
         abort_pulse <= abort_nxt;
         tx_valid    <= load || (tx_valid && !tx_ready);
         if (load) tx_data <= load_data;
      end
   end

endmodule
